alu_issue_sched: RTL and testbench
==================================

Name: alu_issue_sched

Overview:
- Issue scheduler that shares the single combinational integer ALU among NUM_REQ reservation-station ports.
- Round-robin grant feeds a registered issue stage that drives the ALU inputs.
- MUL is held in the issue stage for MUL_LAT cycles so the multiplier path can meet timing.
- Results are registered and handed to writeback/CDB through a valid/ready handshake.

Parameters:
NUM_REQ, 4, number of requesting reservation-station ports (>=2)
MUL_LAT, 3, cycles a MUL occupies the issue stage (>=1)
TAG_W, 6, width of the ROB tag carried with each op

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline squash (branch mispredict)
req_valid  in  NUM_REQ  per-port op ready to issue
req_opcode  in  NUM_REQ x instr_opcode  per-port opcode
req_src1, req_src2, req_imm, req_pc  in  NUM_REQ x 32  per-port operands
req_tag  in  NUM_REQ x TAG_W  per-port ROB tag
req_grant  out  NUM_REQ  one-hot grant, combinational, same cycle
alu_en  out  1  ALU enable (= issue-stage valid)
alu_opcode  out  instr_opcode  ALU opcode from issue register
alu_src1, alu_src2, alu_imm, alu_pc  out  32  ALU operands from issue register
aluout  in  32  ALU result
aluout_valid  in  1  ALU result valid
br_cond  in  1  ALU branch condition
res_valid  out  1  result register valid
res_data  out  32  registered aluout
res_br_cond  out  1  registered br_cond
res_tag  out  TAG_W  ROB tag of result
res_ready  in  1  writeback accepts result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; issue register ir_valid=0; mul_cnt=0; rr_ptr=0; res_valid=0.
  - All data outputs are 0; req_grant=0; alu_en=0.
- FSM states:
  - IDLE: ir_valid=0.
  - EXEC: ir_valid=1, mul_cnt=0.
  - MULW: ir_valid=1, mul_cnt>0.
- Completion: done = ir_valid && mul_cnt==0 && (!res_valid || res_ready).
- Accept: accept = !flush && (!ir_valid || done).
- Grant: if accept and any req_valid, grant exactly one port.
  - Search starts at rr_ptr, ascending, with wrap.
  - On grant, rr_ptr <= (granted index + 1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
  - req_grant depends only on req_valid, rr_ptr and internal state, never on operand data.
- Issue register load: on grant, the granted port's opcode, operands and tag are captured at the next edge; ir_valid=1.
  - If the opcode is MUL, mul_cnt <= MUL_LAT-1; otherwise mul_cnt <= 0.
- mul_cnt decrements by 1 each cycle while >0. It holds at 0 when back-pressured.
- Issue register clear: done with no new grant -> ir_valid <= 0.
- alu_en = ir_valid. ALU inputs are driven straight from the issue register and are stable for the whole occupancy.
- Result register: on done, capture res_data=aluout, res_br_cond=br_cond, res_tag=ir tag; res_valid <= 1.
  - Else if res_ready, res_valid <= 0.
  - Simultaneous res_ready and done: new result replaces the old one; res_valid stays 1.
  - Result data holds its value while res_valid && !res_ready.
- Timing:
  - Non-MUL latency: grant in cycle N -> alu_en in N+1 -> res_valid in N+2. Throughput is 1 op/cycle.
  - MUL latency: grant in N -> res_valid in N+1+MUL_LAT. The next grant can occur in cycle N+MUL_LAT.
  - MUL_LAT=1 behaves as a single-cycle op.
- Back-pressure: with res_valid=1 and res_ready=0, done=0, the issue register holds and no grant is given.
- Flush (priority over all other events):
  - At the next edge: ir_valid=0, mul_cnt=0, res_valid=0, state=IDLE.
  - req_grant=0 in the flush cycle; rr_ptr is retained.
  - A flush mid-MUL abandons the op with no result.
- Assertions:
  - aluout_valid==1 whenever done.
  - req_grant is one-hot or zero.
  - No grant while ir_valid && !done.

Test Plan:
- Reset then all four req_valid=1, res_ready=1, ADD ops with tags 0..3 -> grants in order port0,1,2,3 on consecutive cycles; res_tag 0,1,2,3 starting 2 cycles after the first grant; res_valid continuous.
- Port1 issues ADD src1=5, src2=7 -> res_data=12 exactly two cycles after grant; rr_ptr=2 afterwards.
- MUL src1=-3, src2=4, MUL_LAT=3 -> alu_en high 3 cycles, no grants for cycles N+1..N+2 even with req_valid=4'b1111, res_data=0xFFFFFFF4 at cycle N+4.
- res_ready=0 while two ADDs are in flight -> first result held stable, second held in issue register, req_grant=0; res_ready=1 -> both drain on consecutive cycles, no loss or reordering.
- flush asserted one cycle after a MUL is granted -> res_valid never rises for that tag; state IDLE next cycle; the following grant goes to the next port after the MUL's port.
- rst asserted asynchronously mid-MUL with res_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; after release, first grant goes to port0.

Source files
------------

// File: rtl/alu_issue_sched_if.sv
// Bus bundle between the ALU issue scheduler and its environment.
// It carries three groups of signals:
//   - the reservation-station request ports and their grants,
//   - the ALU operand and result wires,
//   - the registered result handed to writeback with a valid/ready handshake.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface alu_issue_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int OP_W    = 4
);
    // reservation-station request side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][OP_W-1:0]  req_opcode;
    logic [NUM_REQ-1:0][31:0]      req_src1;
    logic [NUM_REQ-1:0][31:0]      req_src2;
    logic [NUM_REQ-1:0][31:0]      req_imm;
    logic [NUM_REQ-1:0][31:0]      req_pc;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]            req_grant;

    // shared combinational ALU
    logic                          alu_en;
    logic [OP_W-1:0]               alu_opcode;
    logic [31:0]                   alu_src1;
    logic [31:0]                   alu_src2;
    logic [31:0]                   alu_imm;
    logic [31:0]                   alu_pc;
    logic [31:0]                   aluout;
    logic                          aluout_valid;
    logic                          br_cond;

    // writeback / CDB handshake
    logic                          res_valid;
    logic [31:0]                   res_data;
    logic                          res_br_cond;
    logic [TAG_W-1:0]              res_tag;
    logic                          res_ready;

    modport slave (
        input  req_valid, req_opcode, req_src1, req_src2, req_imm, req_pc, req_tag,
        output req_grant,
        output alu_en, alu_opcode, alu_src1, alu_src2, alu_imm, alu_pc,
        input  aluout, aluout_valid, br_cond,
        output res_valid, res_data, res_br_cond, res_tag,
        input  res_ready
    );

    modport master (
        output req_valid, req_opcode, req_src1, req_src2, req_imm, req_pc, req_tag,
        input  req_grant,
        input  alu_en, alu_opcode, alu_src1, alu_src2, alu_imm, alu_pc,
        output aluout, aluout_valid, br_cond,
        input  res_valid, res_data, res_br_cond, res_tag,
        output res_ready
    );
endinterface

// File: rtl/alu_issue_sched.sv
// ALU issue scheduler.
// - A round-robin arbiter picks one reservation-station port per cycle and
//   loads its op into a single issue register that drives the shared ALU.
// - MUL ops stay in the issue register for MUL_LAT cycles so the multiplier
//   path gets a multicycle window.
// - The ALU result is captured into a result register and offered to
//   writeback through a valid/ready handshake.
// - flush squashes both stages without disturbing the arbitration pointer.
module alu_issue_sched #(
    parameter int              NUM_REQ = 4,
    parameter int              MUL_LAT = 3,
    parameter int              TAG_W   = 6,
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] OP_MUL  = OP_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_issue_sched_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MULW = 2'd2;

    // issue-stage state
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]   ir_opcode_q, ir_opcode_d;
    logic [31:0]       ir_src1_q, ir_src1_d;
    logic [31:0]       ir_src2_q, ir_src2_d;
    logic [31:0]       ir_imm_q, ir_imm_d;
    logic [31:0]       ir_pc_q, ir_pc_d;
    logic [TAG_W-1:0]  ir_tag_q, ir_tag_d;

    // result-stage state
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              res_br_q, res_br_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    logic              ir_valid;
    logic              done;
    logic              accept;
    logic              grant_found;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;

    logic [NUM_REQ-1:0][PTR_W-1:0] scan_idx;
    logic [NUM_REQ-1:0]            scan_hit;

    // Any non-idle state means the issue register holds a live op.
    assign ir_valid = (state_q != ST_IDLE);

    // The op can retire once the MUL window has elapsed and the result slot
    // is free or being drained this cycle.
    assign done     = ir_valid && (mul_cnt_q == '0) && (!res_valid_q || bus.res_ready);

    // New work is accepted only when the issue register is empty or emptying.
    // Reset is included so the grant is zero while rst is held.
    assign accept   = !rst && !flush && (!ir_valid || done);

    // Rotated view of the request vector:
    // scan position gi corresponds to port (rr_ptr + gi) mod NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
        logic [PTR_W:0] scan_sum;
        assign scan_sum     = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
        assign scan_idx[gi] = (scan_sum >= (PTR_W+1)'(NUM_REQ))
                            ? PTR_W'(scan_sum - (PTR_W+1)'(NUM_REQ))
                            : scan_sum[PTR_W-1:0];
        assign scan_hit[gi] = bus.req_valid[scan_idx[gi]];
    end

    // Pick the first requesting port at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && scan_hit[k]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    assign grant_any = grant_found && accept;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign bus.req_grant[gi] = grant_any && (grant_idx == PTR_W'(gi));
    end

    // Issue register, MUL occupancy counter and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        ir_opcode_d = ir_opcode_q;
        ir_src1_d   = ir_src1_q;
        ir_src2_d   = ir_src2_q;
        ir_imm_d    = ir_imm_q;
        ir_pc_d     = ir_pc_q;
        ir_tag_d    = ir_tag_q;
        if (flush) begin
            state_d   = ST_IDLE;
            mul_cnt_d = '0;
        end else if (grant_any) begin
            ir_opcode_d = bus.req_opcode[grant_idx];
            ir_src1_d   = bus.req_src1[grant_idx];
            ir_src2_d   = bus.req_src2[grant_idx];
            ir_imm_d    = bus.req_imm[grant_idx];
            ir_pc_d     = bus.req_pc[grant_idx];
            ir_tag_d    = bus.req_tag[grant_idx];
            rr_ptr_d    = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
            if (bus.req_opcode[grant_idx] == OP_MUL) begin
                mul_cnt_d = MUL_INIT;
                state_d   = (MUL_INIT != '0) ? ST_MULW : ST_EXEC;
            end else begin
                mul_cnt_d = '0;
                state_d   = ST_EXEC;
            end
        end else if (done) begin
            state_d = ST_IDLE;
        end else if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - CNT_W'(1);
            if (mul_cnt_q == CNT_W'(1)) begin
                state_d = ST_EXEC;
            end
        end
    end

    // Result register: capture on completion, otherwise drain on res_ready.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_br_d    = res_br_q;
        res_tag_d   = res_tag_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (done) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.aluout;
            res_br_d    = bus.br_cond;
            res_tag_d   = ir_tag_q;
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State update with asynchronous clear of every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mul_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            ir_opcode_q <= '0;
            ir_src1_q   <= '0;
            ir_src2_q   <= '0;
            ir_imm_q    <= '0;
            ir_pc_q     <= '0;
            ir_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_br_q    <= 1'b0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ir_opcode_q <= ir_opcode_d;
            ir_src1_q   <= ir_src1_d;
            ir_src2_q   <= ir_src2_d;
            ir_imm_q    <= ir_imm_d;
            ir_pc_q     <= ir_pc_d;
            ir_tag_q    <= ir_tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_br_q    <= res_br_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign bus.alu_en      = ir_valid;
    assign bus.alu_opcode  = ir_opcode_q;
    assign bus.alu_src1    = ir_src1_q;
    assign bus.alu_src2    = ir_src2_q;
    assign bus.alu_imm     = ir_imm_q;
    assign bus.alu_pc      = ir_pc_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_br_cond = res_br_q;
    assign bus.res_tag     = res_tag_q;

    // Protocol invariants, checked at each active edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!done || bus.aluout_valid);
            assert ($onehot0(bus.req_grant));
            assert (!(ir_valid && !done && grant_any));
        end
    end
endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed plus randomized bench for alu_issue_sched.
// The environment is modelled as follows:
//   - the shared ALU is a behavioural function of the alu_* outputs;
//   - expected behaviour comes from an op-level reference model;
//   - the model tracks which op is in the issue slot, how many cycles it has
//     left, and which result sits in the writeback slot.
module tb_alu_issue_sched;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 3;
    localparam int TAG_W   = 6;
    localparam int OP_W    = 4;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_AUIPC = 4'd6;
    localparam logic [3:0] OP_ADDI  = 4'd7;

    logic clk;
    logic rst;
    logic flush;

    alu_issue_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    alu_issue_sched #(
        .NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W), .OP_W(OP_W), .OP_MUL(OP_MUL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                            logic [31:0] imm, logic [31:0] pc);
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_MUL:   return a * b;
            OP_AND:   return a & b;
            OP_XOR:   return a ^ b;
            OP_AUIPC: return pc + imm;
            OP_ADDI:  return a + imm;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        return (op == OP_BEQ) && (a == b);
    endfunction

    // behavioural ALU seen by the scheduler
    assign bus.aluout       = ref_alu(bus.alu_opcode, bus.alu_src1, bus.alu_src2, bus.alu_imm, bus.alu_pc);
    assign bus.br_cond      = ref_br(bus.alu_opcode, bus.alu_src1, bus.alu_src2);
    assign bus.aluout_valid = bus.alu_en;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int          m_rr;
    bit          m_ir_v;
    int          m_left;
    logic [3:0]  m_op;
    logic [31:0] m_s1, m_s2, m_imm, m_pc;
    logic [5:0]  m_tag;
    bit          m_res_v;
    logic [31:0] m_res_d;
    logic        m_res_br;
    logic [5:0]  m_res_tag;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_ir_v  = 0;
        m_left  = 0;
        m_res_v = 0;
    endtask

    task automatic set_op(int p, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [5:0] tag);
        bus.req_opcode[p] = op;
        bus.req_src1[p]   = a;
        bus.req_src2[p]   = b;
        bus.req_imm[p]    = $urandom;
        bus.req_pc[p]     = $urandom;
        bus.req_tag[p]    = tag;
    endtask

    // One clock cycle.
    // Entered just after a negedge with the inputs already driven.
    // The task checks the DUT against the model, advances the model to the
    // next edge, and returns at the following negedge.
    task automatic cycle();
        bit         fin;
        bit         take;
        int         g;
        logic [3:0] exp_g;
        #1;
        fin  = m_ir_v && (m_left == 1) && (!m_res_v || bus.res_ready);
        take = !flush && (!m_ir_v || fin);
        g = -1;
        if (take) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int p;
                p = (m_rr + k) % NUM_REQ;
                if (g < 0 && bus.req_valid[p]) g = p;
            end
        end
        exp_g = (g >= 0) ? 4'(1 << g) : 4'd0;
        chk("req_grant", 64'(bus.req_grant), 64'(exp_g));
        chk("alu_en", 64'(bus.alu_en), 64'(m_ir_v));
        if (m_ir_v) begin
            chk("alu_opcode", 64'(bus.alu_opcode), 64'(m_op));
            chk("alu_src1", 64'(bus.alu_src1), 64'(m_s1));
            chk("alu_src2", 64'(bus.alu_src2), 64'(m_s2));
            chk("alu_imm", 64'(bus.alu_imm), 64'(m_imm));
            chk("alu_pc", 64'(bus.alu_pc), 64'(m_pc));
        end
        chk("res_valid", 64'(bus.res_valid), 64'(m_res_v));
        if (m_res_v) begin
            chk("res_data", 64'(bus.res_data), 64'(m_res_d));
            chk("res_tag", 64'(bus.res_tag), 64'(m_res_tag));
            chk("res_br_cond", 64'(bus.res_br_cond), 64'(m_res_br));
            if (bus.res_ready)
                $display("result tag=%0d data=%08h br=%0b t=%0t", m_res_tag, m_res_d, m_res_br, $time);
        end
        if (flush) begin
            m_ir_v  = 0;
            m_res_v = 0;
        end else begin
            if (fin) begin
                m_res_v   = 1;
                m_res_d   = ref_alu(m_op, m_s1, m_s2, m_imm, m_pc);
                m_res_br  = ref_br(m_op, m_s1, m_s2);
                m_res_tag = m_tag;
            end else if (bus.res_ready) begin
                m_res_v = 0;
            end
            if (g >= 0) begin
                m_ir_v = 1;
                m_op   = bus.req_opcode[g];
                m_s1   = bus.req_src1[g];
                m_s2   = bus.req_src2[g];
                m_imm  = bus.req_imm[g];
                m_pc   = bus.req_pc[g];
                m_tag  = bus.req_tag[g];
                m_left = (m_op == OP_MUL) ? MUL_LAT : 1;
                m_rr   = (g + 1) % NUM_REQ;
            end else if (fin) begin
                m_ir_v = 0;
            end else if (m_ir_v && m_left > 1) begin
                m_left--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.res_ready   = 1'b1;
        bus.req_valid   = '1;
        for (int p = 0; p < NUM_REQ; p++) set_op(p, OP_ADD, 32'(p), 32'(p), 6'(p));
        model_reset();

        // reset state: no grant even with every port requesting
        #3;
        chk("rst_grant", 64'(bus.req_grant), 64'd0);
        chk("rst_alu_en", 64'(bus.alu_en), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // four ADDs back-to-back, tags 0..3, granted in port order
        for (int p = 0; p < NUM_REQ; p++) set_op(p, OP_ADD, 32'(10 * p), 32'(p + 1), 6'(p));
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) cycle();
        idle(3);

        // port1 ADD 5+7 -> 12 two cycles after grant, pointer moves to 2
        set_op(1, OP_ADD, 32'd5, 32'd7, 6'd20);
        bus.req_valid = 4'b0010;
        cycle();
        bus.req_valid = 4'b0000;
        cycle();
        chk("add_res_valid", 64'(bus.res_valid), 64'd1);
        chk("add_res_data", 64'(bus.res_data), 64'd12);
        cycle();
        set_op(2, OP_SUB, 32'd9, 32'd4, 6'd21);
        bus.req_valid = 4'b0110;
        #1;
        chk("rr_after_p1", 64'(bus.req_grant), 64'b0100);
        cycle();
        idle(3);

        // MUL -3*4 on port3: stage blocked two cycles, result at N+4
        set_op(0, OP_ADD, 32'd1, 32'd1, 6'd31);
        set_op(1, OP_ADD, 32'd2, 32'd2, 6'd32);
        set_op(2, OP_ADD, 32'd3, 32'd3, 6'd33);
        set_op(3, OP_MUL, -32'sd3, 32'd4, 6'd30);
        bus.req_valid = 4'b1111;
        #1;
        chk("mul_grant", 64'(bus.req_grant), 64'b1000);
        cycle();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("mul_block_grant", 64'(bus.req_grant), 64'd0);
            chk("mul_alu_en", 64'(bus.alu_en), 64'd1);
            cycle();
        end
        bus.req_valid = 4'b0000;
        cycle();
        chk("mul_res_data", 64'(bus.res_data), 64'hFFFF_FFF4);
        chk("mul_res_tag", 64'(bus.res_tag), 64'd30);
        idle(3);

        // back-pressure with two ADDs in flight
        bus.res_ready = 1'b0;
        set_op(0, OP_ADD, 32'd100, 32'd1, 6'd10);
        set_op(1, OP_ADD, 32'd200, 32'd2, 6'd11);
        bus.req_valid = 4'b0011;
        cycle();
        cycle();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_grant", 64'(bus.req_grant), 64'd0);
            chk("bp_res_tag", 64'(bus.res_tag), 64'd10);
            chk("bp_res_data", 64'(bus.res_data), 64'd101);
            chk("bp_ir_src1", 64'(bus.alu_src1), 64'd200);
            cycle();
        end
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0000;
        cycle();
        chk("bp_drain_tag", 64'(bus.res_tag), 64'd11);
        chk("bp_drain_data", 64'(bus.res_data), 64'd202);
        idle(3);

        // flush one cycle after a MUL grant
        set_op(1, OP_MUL, 32'd6, 32'd7, 6'd40);
        bus.req_valid = 4'b0010;
        cycle();
        set_op(2, OP_ADD, 32'd8, 32'd8, 6'd41);
        bus.req_valid = 4'b1111;
        flush = 1'b1;
        #1;
        chk("flush_grant", 64'(bus.req_grant), 64'd0);
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_idle", 64'(bus.alu_en), 64'd0);
        chk("flush_res_valid", 64'(bus.res_valid), 64'd0);
        chk("flush_next_grant", 64'(bus.req_grant), 64'b0100);
        cycle();
        idle(4);

        // asynchronous reset mid-MUL with a result waiting
        bus.res_ready = 1'b0;
        set_op(2, OP_ADD, 32'd50, 32'd5, 6'd50);
        bus.req_valid = 4'b0100;
        cycle();
        set_op(3, OP_MUL, 32'd9, 32'd9, 6'd51);
        bus.req_valid = 4'b1000;
        cycle();
        chk("pre_rst_res_valid", 64'(bus.res_valid), 64'd1);
        bus.req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("arst_res_data", 64'(bus.res_data), 64'd0);
        chk("arst_res_tag", 64'(bus.res_tag), 64'd0);
        chk("arst_alu_en", 64'(bus.alu_en), 64'd0);
        chk("arst_alu_src1", 64'(bus.alu_src1), 64'd0);
        chk("arst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
        chk("arst_grant", 64'(bus.req_grant), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        chk("post_rst_grant", 64'(bus.req_grant), 64'b0001);
        cycle();
        idle(3);

        // randomized traffic with back-pressure and occasional flush
        for (int i = 0; i < 1000; i++) begin
            for (int p = 0; p < NUM_REQ; p++) begin
                logic [31:0] a;
                a = $urandom;
                set_op(p, 4'($urandom_range(0, 7)), a,
                       ($urandom_range(0, 3) == 0) ? a : 32'($urandom), 6'($urandom));
            end
            bus.req_valid = 4'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush = 1'b0;
        bus.res_ready = 1'b1;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
